pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_skid_reg_d_ff_en.sv | 29 ++
 rtl/pipe_skid_reg.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_pkg                                                                   |
// | Shared definitions for the pipeline skid register: the three-state         |
// | occupancy FSM encoding used by pipe_skid_reg.                              |
// | Ports: none (package).                                                     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package pipe_pkg;

  localparam int STATE_W = 2;

  // EMPTY: no entries; BUSY: main register valid; FULL: main and skid valid.
  typedef enum logic [STATE_W-1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_skid_reg_d_ff_en.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | D_FF_en                                                                    |
// | Single-bit D flip-flop with synchronous active-high reset and load enable. |
// | Ports: clk   - clock                                                       |
// |        reset - synchronous reset, clears q to 0                            |
// |        en    - load enable                                                 |
// |        d     - data in                                                     |
// |        q     - registered data out                                         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module D_FF_en (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : D_FF_en
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_skid_reg                                                              |
// | Two-entry pipeline skid register. in_ready is registered so that the       |
// | upstream ready path is fully decoupled from out_ready; the skid register   |
// | absorbs the one payload that can arrive while the stall propagates.        |
// | Ports: clk, reset     - clock, synchronous active-high reset               |
// |        flush          - squash all buffered entries on the next edge      |
// |        in_valid/ready - upstream handshake, in_data payload               |
// |        out_valid/ready- downstream handshake, out_data payload            |
// |        occupancy      - number of buffered entries (0..2)                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  state_t           state;
  state_t           state_next;
  logic             in_ready_q;
  logic             main_valid;
  logic             skid_valid;
  logic             accept_in;
  logic             accept_out;
  logic             main_en;
  logic             skid_en;
  logic             main_sel_skid;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  // Valid bits are the decoded FSM state: one source of truth for occupancy.
  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == FULL);

  assign accept_in  = in_valid & in_ready_q;
  assign accept_out = main_valid & out_ready;

  // ---------------------------------------------------------------------------
  // State register. in_ready is registered from the next state so it never
  // depends combinationally on out_ready.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != FULL);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and register-enable logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    main_en       = 1'b0;
    skid_en       = 1'b0;
    main_sel_skid = 1'b0;

    if (flush) begin
      // Squash everything; data registers keep their stale contents.
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept_in) begin
            state_next = BUSY;
            main_en    = 1'b1;
          end
        end
        BUSY: begin
          if (accept_in && accept_out) begin
            main_en = 1'b1;
          end else if (accept_in) begin
            state_next = FULL;
            skid_en    = 1'b1;
          end else if (accept_out) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so no new payload can arrive.
          if (accept_out) begin
            state_next    = BUSY;
            main_en       = 1'b1;
            main_sel_skid = 1'b1;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  assign main_d = main_sel_skid ? skid_q : in_data;

  // ---------------------------------------------------------------------------
  // Per-bit storage.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    D_FF_en u_main_ff (
      .clk   (clk),
      .reset (reset),
      .en    (main_en),
      .d     (main_d[i]),
      .q     (main_q[i])
    );

    D_FF_en u_skid_ff (
      .clk   (clk),
      .reset (reset),
      .en    (skid_en),
      .d     (in_data[i]),
      .q     (skid_q[i])
    );
  end : g_bit

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_q;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule : pipe_skid_reg
`default_nettype wire
